// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_meter
//  Description : Energy-pulse measurement unit. Counts rising edges of an
//                asynchronous meter pulse inside each gate window (rising
//                edges of Tick), measures the pulse-to-pulse period in Clk
//                cycles, and latches both at every window close into a
//                result register pair read through a valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_meter #(
    parameter int CNT_W = 16,
    parameter int PER_W = 24
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             PulseIn,
    input  logic             Tick,
    input  logic             Ack,
    output logic [CNT_W-1:0] Count,
    output logic [PER_W-1:0] Period,
    output logic             Valid,
    output logic             Overrun,
    output logic             CntSat
);

    // Gate FSM encoding
    localparam logic [0:0] c_GATE_IDLE    = 1'b0;
    localparam logic [0:0] c_GATE_MEASURE = 1'b1;

    // Period tracker encoding
    localparam logic [1:0] c_TRK_NONE  = 2'd0;
    localparam logic [1:0] c_TRK_ONE   = 2'd1;
    localparam logic [1:0] c_TRK_TRACK = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [PER_W-1:0] c_PER_MAX = {PER_W{1'b1}};

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_t_d;
    logic w_pev;
    logic w_wev;

    // Two-flop synchronizer plus one delay flop for edge detection, and
    // a single register on Tick (already synchronous to Clk).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_t_d <= 1'b0;
        end else begin
            r_s1  <= PulseIn;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_t_d <= Tick;
        end
    end

    assign w_pev = r_s2 & ~r_s3;
    assign w_wev = Tick & ~r_t_d;

    // ------------------------------------------------------------------
    // Gate FSM
    // ------------------------------------------------------------------
    logic [0:0] r_gate_st;
    logic [0:0] w_gate_nxt;
    logic       w_close;

    // Gate state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_gate_st <= c_GATE_IDLE;
        end else begin
            r_gate_st <= w_gate_nxt;
        end
    end

    // Next gate state; a window closes on every edge seen while measuring.
    // The arming edge out of IDLE never closes a window, so the partial
    // window before it is dropped.
    always_comb begin
        w_gate_nxt = r_gate_st;
        w_close    = 1'b0;
        if (!En) begin
            w_gate_nxt = c_GATE_IDLE;
        end else begin
            case (r_gate_st)
                c_GATE_IDLE: begin
                    if (w_wev) begin
                        w_gate_nxt = c_GATE_MEASURE;
                    end
                end
                c_GATE_MEASURE: begin
                    w_close = w_wev;
                end
                default: begin
                    w_gate_nxt = c_GATE_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window pulse counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_win_cnt;
    logic             r_sat;
    logic             w_win_max;
    logic [CNT_W-1:0] w_win_sum;
    logic             w_win_ovf;

    assign w_win_max = (r_win_cnt == c_CNT_MAX);
    // A pulse coincident with the closing edge belongs to the closing window.
    assign w_win_sum = w_win_max ? r_win_cnt : (r_win_cnt + CNT_W'(w_pev));
    assign w_win_ovf = w_win_max & w_pev;

    // Saturating per-window count; restarts at zero after each close.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_win_cnt <= '0;
            r_sat     <= 1'b0;
        end else if (!En || w_close) begin
            r_win_cnt <= '0;
            r_sat     <= 1'b0;
        end else if ((r_gate_st == c_GATE_MEASURE) && w_pev) begin
            if (w_win_max) begin
                r_sat <= 1'b1;
            end else begin
                r_win_cnt <= r_win_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Period tracker
    // ------------------------------------------------------------------
    logic [1:0]       r_trk_st;
    logic [1:0]       w_trk_nxt;
    logic [PER_W-1:0] r_per_cnt;
    logic [PER_W-1:0] r_last_per;
    logic             w_per_max;
    logic [PER_W-1:0] w_per_inc;

    assign w_per_max = (r_per_cnt == c_PER_MAX);
    assign w_per_inc = w_per_max ? c_PER_MAX : (r_per_cnt + PER_W'(1));

    // Tracker state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_trk_st <= c_TRK_NONE;
        end else begin
            r_trk_st <= w_trk_nxt;
        end
    end

    // Tracker advances on each pulse; needs two pulses before an interval
    // is known.
    always_comb begin
        w_trk_nxt = r_trk_st;
        if (!En) begin
            w_trk_nxt = c_TRK_NONE;
        end else if (w_pev) begin
            case (r_trk_st)
                c_TRK_NONE:  w_trk_nxt = c_TRK_ONE;
                c_TRK_ONE:   w_trk_nxt = c_TRK_TRACK;
                c_TRK_TRACK: w_trk_nxt = c_TRK_TRACK;
                default:     w_trk_nxt = c_TRK_NONE;
            endcase
        end
    end

    // Cycle counter between pulses; a saturated counter means the pulse
    // stream has stopped, so the last interval is reported as all-ones.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_per_cnt  <= '0;
            r_last_per <= '0;
        end else if (!En) begin
            r_per_cnt <= '0;
        end else if (w_pev) begin
            r_per_cnt <= '0;
            if (r_trk_st != c_TRK_NONE) begin
                r_last_per <= w_per_inc;
            end
        end else if (w_per_max) begin
            r_last_per <= c_PER_MAX;
        end else begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers and handshake
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_count;
    logic [PER_W-1:0] r_period;
    logic             r_cnt_sat;
    logic             r_valid;
    logic             r_overrun;
    logic             w_ack_hit;

    assign w_ack_hit = Ack & r_valid;

    // Result latch at each window close; holds otherwise (including En=0).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count   <= '0;
            r_period  <= '0;
            r_cnt_sat <= 1'b0;
        end else if (w_close) begin
            r_count   <= w_win_sum;
            r_cnt_sat <= r_sat | w_win_ovf;
            r_period  <= (r_trk_st == c_TRK_TRACK) ? r_last_per : '0;
        end
    end

    // Valid/overrun handshake; an ack in the same cycle as a close
    // consumes the old result, so the new one is not an overrun.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_close) begin
            r_valid <= 1'b1;
            if (w_ack_hit) begin
                r_overrun <= 1'b0;
            end else if (r_valid) begin
                r_overrun <= 1'b1;
            end
        end else if (w_ack_hit) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign Count   = r_count;
    assign Period  = r_period;
    assign CntSat  = r_cnt_sat;
    assign Valid   = r_valid;
    assign Overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_meter
//  Description : Self-checking bench for pulse_meter. An event-level model
//                (pulse arrival times, window boundaries, interval
//                arithmetic) predicts the result registers every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_meter;

    localparam int CNT_W = 4;
    localparam int PER_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int PMAX  = (1 << PER_W) - 1;

    logic             clk = 1'b0;
    logic             Reset;
    logic             En;
    logic             PulseIn;
    logic             Tick;
    logic             Ack;
    logic [CNT_W-1:0] Count;
    logic [PER_W-1:0] Period;
    logic             Valid;
    logic             Overrun;
    logic             CntSat;

    pulse_meter #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .Clk     (clk),
        .Reset   (Reset),
        .En      (En),
        .PulseIn (PulseIn),
        .Tick    (Tick),
        .Ack     (Ack),
        .Count   (Count),
        .Period  (Period),
        .Valid   (Valid),
        .Overrun (Overrun),
        .CntSat  (CntSat)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    // ------------------------------------------------------------------
    // Stimulus generator state
    // ------------------------------------------------------------------
    int pper = 100, pwid = 4, pcnt = 0;
    bit pon = 1'b0;
    int tper = 1000, tcnt = 0;
    int ack_pct = 0;

    task automatic gen();
        if (pon) PulseIn = (pcnt < pwid);
        else     PulseIn = 1'b0;
        pcnt = (pcnt + 1) % pper;
        Tick = (tcnt < tper / 2);
        tcnt = (tcnt + 1) % tper;
        Ack  = ($urandom_range(99) < ack_pct);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            gen();
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Event-level reference model
    // ------------------------------------------------------------------
    int m_edge = 0;
    int m_due[$];          // edge numbers at which a detected pulse is seen
    bit m_prev_samp, m_tick_prev, m_armed;
    int m_win, m_np, m_p1, m_p2, m_n, m_per;
    bit m_pev, m_wev, m_close;

    logic [CNT_W-1:0] e_count;
    logic [PER_W-1:0] e_period;
    logic             e_valid, e_ovr, e_sat;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_due.delete();
            m_prev_samp = 1'b0;
            m_tick_prev = 1'b0;
            m_armed     = 1'b0;
            m_win = 0; m_np = 0; m_p1 = 0; m_p2 = 0;
            e_count = '0; e_period = '0; e_valid = 1'b0; e_ovr = 1'b0; e_sat = 1'b0;
        end else begin
            m_edge++;
            m_pev = (m_due.size() > 0) && (m_due[0] == m_edge);
            if (m_pev) void'(m_due.pop_front());
            m_wev   = Tick && !m_tick_prev;
            m_close = En && m_wev && m_armed;

            if (m_close) begin
                m_n      = m_win + int'(m_pev);
                e_count  = CNT_W'((m_n > CMAX) ? CMAX : m_n);
                e_sat    = (m_n > CMAX);
                if (m_np >= 2) begin
                    m_per = ((m_p2 - m_p1) > PMAX) ? PMAX : (m_p2 - m_p1);
                    if ((m_edge - m_p2) >= PMAX + 2) m_per = PMAX;
                    e_period = PER_W'(m_per);
                end else begin
                    e_period = '0;
                end
                if (Ack && e_valid) e_ovr = 1'b0;
                else if (e_valid)   e_ovr = 1'b1;
                e_valid = 1'b1;
            end else if (Ack && e_valid) begin
                e_valid = 1'b0;
                e_ovr   = 1'b0;
            end

            if (!En) begin
                m_armed = 1'b0;
                m_win   = 0;
                m_np    = 0;
            end else begin
                if (m_close)               m_win = 0;
                else if (m_armed && m_pev) m_win++;
                if (m_wev) m_armed = 1'b1;
                if (m_pev) begin
                    m_p1 = m_p2;
                    m_p2 = m_edge;
                    m_np++;
                end
            end

            if (PulseIn && !m_prev_samp) m_due.push_back(m_edge + 2);
            m_prev_samp = PulseIn;
            m_tick_prev = Tick;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if (Count !== e_count || Period !== e_period || Valid !== e_valid ||
                Overrun !== e_ovr || CntSat !== e_sat) begin
                miscompares++;
                $display("FAIL cycle t=%0t: Count %0d/%0d Period %0d/%0d Valid %0b/%0b Overrun %0b/%0b CntSat %0b/%0b (got/expected)",
                         $time, Count, e_count, Period, e_period, Valid, e_valid,
                         Overrun, e_ovr, CntSat, e_sat);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus sequence
    // ------------------------------------------------------------------
    initial begin
        Reset = 1'b0; En = 1'b0; PulseIn = 1'b0; Tick = 1'b0; Ack = 1'b0;
        #1 Reset = 1'b1;
        #2 chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", int'(Count), 0);
        chk("reset_valid", int'(Valid), 0);
        Reset = 1'b0;
        En    = 1'b1;

        // Nominal: window 1000, pulses every 100, first pulse 10 after arm
        pper = 100; pwid = 4; pcnt = 90; pon = 1'b1;
        tper = 1000; tcnt = 500; ack_pct = 0;
        run(3600);
        chk("nom_count",   int'(Count),   10);
        chk("nom_period",  int'(Period),  100);
        chk("nom_valid",   int'(Valid),   1);
        chk("nom_overrun", int'(Overrun), 1);
        chk("nom_cntsat",  int'(CntSat),  0);

        // Ack clears valid and overrun on the next edge
        @(posedge clk); #1; gen(); Ack = 1'b1;
        @(posedge clk); #1; gen();
        chk("ack_valid",   int'(Valid),   0);
        chk("ack_overrun", int'(Overrun), 0);

        // Pulse stream stops: period reports all-ones
        pon = 1'b0;
        run(2300);
        chk("nopulse_count",  int'(Count),  0);
        chk("nopulse_period", int'(Period), PMAX);

        // Saturation: far more than CMAX pulses in one window
        pon = 1'b1; pper = 10; pwid = 4; pcnt = 0;
        run(1000);
        chk("sat_count",  int'(Count),  CMAX);
        chk("sat_flag",   int'(CntSat), 1);
        chk("sat_period", int'(Period), 10);

        // Sparse pulses: saturation flag clears on the next window
        pper = 300; pwid = 4;
        run(2100);
        chk("sat_clear", int'(CntSat), 0);

        // Coincident pulse and window edge, with ack on the same edge
        pper = 100; pwid = 4; pcnt = 2; tper = 600; tcnt = 300;
        for (int i = 0; i <= 950; i++) begin
            @(posedge clk); #1; gen();
            Ack = (i == 900);
        end
        chk("coin_count",   int'(Count),   6);
        chk("coin_period",  int'(Period),  100);
        chk("coin_valid",   int'(Valid),   1);
        chk("coin_overrun", int'(Overrun), 0);
        run(600);

        // Asynchronous reset mid-window
        Reset = 1'b1;
        #1;
        chk("areset_count",  int'(Count),  0);
        chk("areset_period", int'(Period), 0);
        chk("areset_valid",  int'(Valid),  0);
        run(3);
        @(posedge clk); #1;
        Reset = 1'b0; pon = 1'b0; tper = 1000; tcnt = 500;
        gen();
        run(999);
        chk("rearm_no_valid", int'(Valid), 0);
        run(1000);
        chk("rearm_valid",  int'(Valid),  1);
        chk("rearm_period", int'(Period), 0);
        chk("rearm_count",  int'(Count),  0);

        // Enable dropped for 50 cycles, then resumes
        En = 1'b0;
        run(50);
        En = 1'b1; pon = 1'b1; pper = 100; pwid = 4; ack_pct = 5;
        run(3000);

        // Randomized segments
        for (int s = 0; s < 20; s++) begin
            pper    = $urandom_range(300, 6);
            pwid    = $urandom_range(pper - 2, 2);
            tper    = 2 * $urandom_range(700, 60);
            pon     = ($urandom_range(4) != 0);
            ack_pct = $urandom_range(30);
            if ($urandom_range(3) == 0) begin
                En = 1'b0;
                run($urandom_range(100, 5));
                En = 1'b1;
            end
            if ($urandom_range(5) == 0) begin
                @(posedge clk); #1; gen();
                Reset = 1'b1;
                run(2);
                @(posedge clk); #1; gen();
                Reset = 1'b0;
            end
            run(1500);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
